// File: rtl/post_norm_addsub_if.sv
// Bundles the operand inputs and the result outputs of the add/sub
// post-normalization unit. The master drives operations and the slave
// (the unit itself) returns packed results and exception flags.
interface post_norm_addsub_if;
  logic        in_valid;
  logic [27:0] fract_in;
  logic [7:0]  exp_in;
  logic        sign;
  logic        zero_sign;
  logic        nan_sign;
  logic        nan_in;
  logic        inf_in;
  logic [1:0]  rmode;

  logic [31:0] out;
  logic        out_valid;
  logic        ine;
  logic        overflow;
  logic        underflow;
  logic        zero;

  modport master (
    output in_valid, fract_in, exp_in, sign, zero_sign, nan_sign,
           nan_in, inf_in, rmode,
    input  out, out_valid, ine, overflow, underflow, zero
  );

  modport slave (
    input  in_valid, fract_in, exp_in, sign, zero_sign, nan_sign,
           nan_in, inf_in, rmode,
    output out, out_valid, ine, overflow, underflow, zero
  );
endinterface

// File: rtl/post_norm_addsub.sv
// Post-normalization and rounding for the single-precision add/sub path.
// Stage 1 normalizes the 28-bit raw sum (carry right-shift or leading-zero
// left-shift limited by the exponent), stage 2 rounds, detects overflow and
// underflow and packs the IEEE-754 word. NaN/Inf requests bypass rounding
// but travel through the same two stages so latency is constant.
module post_norm_addsub #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int LAT    = 2
) (
  input  logic               clk,
  input  logic               reset,
  post_norm_addsub_if.slave  bus
);

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // Valid shift register, one bit per pipeline stage.
  logic [LAT-1:0] valid_q, valid_d;

  // Stage 1 registers: normalized mantissa and exponent plus specials.
  logic [26:0]    mant_q, mant_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic           sign_q, sign_d;
  logic [1:0]     rmode_q, rmode_d;
  logic           nan_q, nan_d;
  logic           inf_q, inf_d;
  logic           nan_sign_q, nan_sign_d;

  // Stage 2 registers: packed result and flags.
  logic [31:0]    out_q, out_d;
  logic           ine_q, ine_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           zero_q, zero_d;

  // Stage 1 working signals.
  logic [EXP_W:0] eff_exp;
  logic [EXP_W:0] exp_m1;
  logic [4:0]     lz;
  logic [4:0]     sh;
  logic [26:0]    shifted;
  logic [26:0]    norm_mant;
  logic [EXP_W:0] norm_exp;
  logic           norm_sign;

  // Stage 2 working signals.
  logic              g_bit, rs_bit, lsb_bit, inc;
  logic [24:0]       sum;
  logic [EXP_W:0]    rexp;
  logic [FRAC_W-1:0] rman;
  logic              inexact;
  logic              to_inf;

  // Normalize the incoming raw sum and select what stage 1 captures.
  always_comb begin
    valid_d = {valid_q[LAT-2:0], bus.in_valid};

    eff_exp = (bus.exp_in == '0) ? {{EXP_W{1'b0}}, 1'b1} : {1'b0, bus.exp_in};
    exp_m1  = eff_exp - 1'b1;

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (bus.fract_in[i]) lz = 5'(26 - i);
    end

    sh      = ({4'b0, lz} < exp_m1) ? lz : exp_m1[4:0];
    shifted = bus.fract_in[26:0] << sh;

    norm_mant = '0;
    norm_exp  = '0;
    norm_sign = bus.sign;
    if (bus.fract_in == '0) begin
      norm_sign = bus.inf_in ? bus.sign : bus.zero_sign;
    end else if (bus.fract_in[27]) begin
      norm_mant = {bus.fract_in[27:2], bus.fract_in[1] | bus.fract_in[0]};
      norm_exp  = eff_exp + 1'b1;
    end else begin
      norm_mant = shifted;
      norm_exp  = shifted[26] ? (eff_exp - {4'b0, sh}) : '0;
    end

    mant_d     = mant_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    rmode_d    = rmode_q;
    nan_d      = nan_q;
    inf_d      = inf_q;
    nan_sign_d = nan_sign_q;
    if (bus.in_valid) begin
      mant_d     = norm_mant;
      exp_d      = norm_exp;
      sign_d     = norm_sign;
      rmode_d    = bus.rmode;
      nan_d      = bus.nan_in;
      inf_d      = bus.inf_in;
      nan_sign_d = bus.nan_sign;
    end
  end

  // Round the normalized value, detect exceptions and pack the result.
  always_comb begin
    lsb_bit = mant_q[3];
    g_bit   = mant_q[2];
    rs_bit  = mant_q[1] | mant_q[0];

    inc = 1'b0;
    case (rmode_q)
      2'd0: inc = g_bit & (rs_bit | lsb_bit);
      2'd1: inc = 1'b0;
      2'd2: inc = ~sign_q & (g_bit | rs_bit);
      2'd3: inc = sign_q & (g_bit | rs_bit);
      default: inc = 1'b0;
    endcase

    sum  = {1'b0, mant_q[26:3]} + {24'b0, inc};
    rexp = exp_q;
    rman = sum[FRAC_W-1:0];
    if (sum[24]) begin
      rexp = exp_q + 1'b1;
      rman = '0;
    end else if ((exp_q == '0) && sum[23]) begin
      rexp = {{EXP_W{1'b0}}, 1'b1};
    end

    inexact = g_bit | rs_bit;
    to_inf  = (rmode_q == 2'd0) || ((rmode_q == 2'd2) && !sign_q) ||
              ((rmode_q == 2'd3) && sign_q);

    out_d       = out_q;
    ine_d       = ine_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;
    if (valid_q[0]) begin
      ine_d       = inexact;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      zero_d      = 1'b0;
      if (nan_q) begin
        out_d  = {nan_sign_q, 8'hFF, 1'b1, 22'b0};
        ine_d  = 1'b0;
      end else if (inf_q) begin
        out_d  = {sign_q, 8'hFF, 23'b0};
        ine_d  = 1'b0;
      end else if (rexp >= EXP_MAX) begin
        overflow_d = 1'b1;
        ine_d      = 1'b1;
        out_d      = to_inf ? {sign_q, 8'hFF, 23'b0} : {sign_q, 8'hFE, 23'h7FFFFF};
      end else begin
        out_d       = {sign_q, rexp[EXP_W-1:0], rman};
        underflow_d = (rexp == '0) & inexact;
        zero_d      = (rexp == '0) && (rman == '0);
      end
    end
  end

  // Pipeline state; reset discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      rmode_q     <= '0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      nan_sign_q  <= 1'b0;
      out_q       <= '0;
      ine_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      rmode_q     <= rmode_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
      nan_sign_q  <= nan_sign_d;
      out_q       <= out_d;
      ine_q       <= ine_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q[LAT-1];
  assign bus.ine       = ine_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_post_norm_addsub.sv
// Testbench for post_norm_addsub: directed vectors with hand-computed
// results, then randomized traffic checked against a behavioural model,
// all matched through an in-order scoreboard queue.
module tb_post_norm_addsub;

  typedef struct packed {
    logic [31:0] out;
    logic        ine;
    logic        ovf;
    logic        unf;
    logic        zero;
  } result_t;

  typedef struct packed {
    logic [27:0] fract;
    logic [7:0]  exp;
    logic        sign;
    logic        zsign;
    logic        nsign;
    logic        nan;
    logic        inf;
    logic [1:0]  rmode;
  } stim_t;

  logic clk;
  logic reset;
  post_norm_addsub_if bus ();

  post_norm_addsub dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int      checks = 0;
  int      errors = 0;
  result_t sb[$];
  result_t last_exp = '0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Behavioural reference written as an iterative normalize/round.
  function automatic result_t model(input stim_t st);
    result_t     r;
    int          e;
    logic [27:0] f;
    logic [24:0] m;
    logic        g, rs, lsb, inc, ine;
    r = '0;
    if (st.nan) begin
      r.out = {st.nsign, 8'hFF, 1'b1, 22'b0};
    end else if (st.inf) begin
      r.out = {st.sign, 8'hFF, 23'b0};
    end else if (st.fract == 0) begin
      r.out  = {st.zsign, 31'b0};
      r.zero = 1'b1;
    end else begin
      e = (st.exp == 0) ? 1 : int'(st.exp);
      f = st.fract;
      if (f[27]) begin
        f    = {1'b0, f[27:1]};
        f[0] = f[0] | st.fract[0];
        e++;
      end else begin
        while (!f[26] && e > 1) begin
          f = f << 1;
          e--;
        end
        if (!f[26]) e = 0;
      end
      lsb = f[3];
      g   = f[2];
      rs  = f[1] | f[0];
      case (st.rmode)
        2'd0:    inc = g & (rs | lsb);
        2'd2:    inc = !st.sign & (g | rs);
        2'd3:    inc = st.sign & (g | rs);
        default: inc = 1'b0;
      endcase
      m = {1'b0, f[26:3]} + 25'(inc);
      if (m[24]) begin
        e++;
        m = 25'h0800000;
      end else if (e == 0 && m[23]) begin
        e = 1;
      end
      ine = g | rs;
      if (e >= 255) begin
        r.ovf = 1'b1;
        r.ine = 1'b1;
        if (st.rmode == 2'd0 || (st.rmode == 2'd2 && !st.sign) ||
            (st.rmode == 2'd3 && st.sign))
          r.out = {st.sign, 8'hFF, 23'b0};
        else
          r.out = {st.sign, 8'hFE, 23'h7FFFFF};
      end else begin
        r.out  = {st.sign, 8'(e), m[22:0]};
        r.ine  = ine;
        r.unf  = (e == 0) && ine;
        r.zero = (e == 0) && (m[22:0] == 0);
      end
    end
    return r;
  endfunction

  // Present one operation for one cycle and queue its expected result.
  task automatic applyStimulus(input stim_t st, input result_t expected);
    bus.in_valid  = 1'b1;
    bus.fract_in  = st.fract;
    bus.exp_in    = st.exp;
    bus.sign      = st.sign;
    bus.zero_sign = st.zsign;
    bus.nan_sign  = st.nsign;
    bus.nan_in    = st.nan;
    bus.inf_in    = st.inf;
    bus.rmode     = st.rmode;
    sb.push_back(expected);
    @(posedge clk);
    #1;
  endtask

  task automatic driveIdle();
    bus.in_valid = 1'b0;
    bus.nan_in   = 1'b0;
    bus.inf_in   = 1'b0;
  endtask

  function automatic stim_t mkStim(input logic [27:0] fract, input logic [7:0] exp,
                                   input logic sign, input logic [1:0] rmode);
    stim_t s;
    s       = '0;
    s.fract = fract;
    s.exp   = exp;
    s.sign  = sign;
    s.rmode = rmode;
    return s;
  endfunction

  function automatic result_t mkRes(input logic [31:0] out, input logic ine,
                                    input logic ovf, input logic unf, input logic zero);
    result_t r;
    r.out  = out;
    r.ine  = ine;
    r.ovf  = ovf;
    r.unf  = unf;
    r.zero = zero;
    return r;
  endfunction

  // Compare every produced result against the scoreboard head; while idle
  // the outputs must keep the last delivered result.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          result_t e;
          e = sb.pop_front();
          last_exp = e;
          checkOutput("out",       bus.out,             e.out);
          checkOutput("ine",       32'(bus.ine),        32'(e.ine));
          checkOutput("overflow",  32'(bus.overflow),   32'(e.ovf));
          checkOutput("underflow", 32'(bus.underflow),  32'(e.unf));
          checkOutput("zero",      32'(bus.zero),       32'(e.zero));
        end
      end else begin
        checkOutput("hold_out", bus.out, last_exp.out);
      end
    end
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    stim_t s;
    int    sel;

    reset = 1'b1;
    bus.fract_in  = '0;
    bus.exp_in    = '0;
    bus.sign      = 1'b0;
    bus.zero_sign = 1'b0;
    bus.nan_sign  = 1'b0;
    bus.rmode     = '0;
    driveIdle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out",       bus.out,            32'd0);
    checkOutput("rst_flags", {28'd0, bus.ine, bus.overflow, bus.underflow, bus.zero}, 32'd0);

    // 1.0 + 1.0 with explicit latency check.
    @(posedge clk); #1;
    applyStimulus(mkStim(28'h8000000, 8'd127, 1'b0, 2'd0), mkRes(32'h40000000, 0, 0, 0, 0));
    driveIdle();
    @(negedge clk);
    checkOutput("latency_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_cycle2", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    // Directed vectors streamed back-to-back.
    applyStimulus(mkStim(28'h0000008, 8'd127, 1'b0, 2'd0), mkRes(32'h34000000, 0, 0, 0, 0));
    applyStimulus(mkStim(28'h4000004, 8'd127, 1'b0, 2'd0), mkRes(32'h3F800000, 1, 0, 0, 0));
    applyStimulus(mkStim(28'h4000004, 8'd127, 1'b0, 2'd2), mkRes(32'h3F800001, 1, 0, 0, 0));
    applyStimulus(mkStim(28'h4000004, 8'd127, 1'b0, 2'd1), mkRes(32'h3F800000, 1, 0, 0, 0));
    applyStimulus(mkStim(28'h4000004, 8'd127, 1'b1, 2'd3), mkRes(32'hBF800001, 1, 0, 0, 0));
    applyStimulus(mkStim(28'h7FFFFFC, 8'd127, 1'b0, 2'd0), mkRes(32'h40000000, 1, 0, 0, 0));
    applyStimulus(mkStim(28'h8000000, 8'd254, 1'b0, 2'd0), mkRes(32'h7F800000, 1, 1, 0, 0));
    applyStimulus(mkStim(28'h8000000, 8'd254, 1'b0, 2'd1), mkRes(32'h7F7FFFFF, 1, 1, 0, 0));
    applyStimulus(mkStim(28'h0000010, 8'd0,   1'b0, 2'd0), mkRes(32'h00000002, 0, 0, 0, 0));
    applyStimulus(mkStim(28'h0000005, 8'd0,   1'b0, 2'd0), mkRes(32'h00000001, 1, 0, 1, 0));
    s = mkStim(28'h0, 8'd90, 1'b0, 2'd0);
    s.zsign = 1'b1;
    applyStimulus(s, mkRes(32'h80000000, 0, 0, 0, 1));
    s = mkStim(28'h4000004, 8'd127, 1'b0, 2'd0);
    s.nan = 1'b1;
    s.nsign = 1'b1;
    applyStimulus(s, mkRes(32'hFFC00000, 0, 0, 0, 0));
    s = mkStim(28'h0, 8'd0, 1'b1, 2'd0);
    s.inf = 1'b1;
    applyStimulus(s, mkRes(32'hFF800000, 0, 0, 0, 0));
    driveIdle();
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with occasional idle gaps.
    for (int n = 0; n < 120; n++) begin
      s = '0;
      sel = $urandom_range(0, 3);
      case (sel)
        0: s.fract = 28'($urandom);
        1: s.fract = 28'($urandom) >> $urandom_range(0, 27);
        2: s.fract = 28'h8000000 | 28'($urandom_range(0, 32'h7FFFFFF));
        default: s.fract = 28'($urandom_range(0, 31));
      endcase
      sel = $urandom_range(0, 5);
      case (sel)
        0: s.exp = 8'd0;
        1: s.exp = 8'($urandom_range(254, 255));
        default: s.exp = 8'($urandom_range(1, 253));
      endcase
      s.sign  = 1'($urandom);
      s.zsign = 1'($urandom);
      s.nsign = 1'($urandom);
      s.rmode = 2'($urandom);
      s.nan   = ($urandom_range(0, 15) == 0);
      s.inf   = ($urandom_range(0, 15) == 0);
      applyStimulus(s, model(s));
      if ($urandom_range(0, 3) == 0) begin
        driveIdle();
        @(posedge clk); #1;
      end
    end
    driveIdle();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Reset with two operations in flight.
    applyStimulus(mkStim(28'h8000000, 8'd127, 1'b0, 2'd0), mkRes(32'h40000000, 0, 0, 0, 0));
    applyStimulus(mkStim(28'h0000008, 8'd127, 1'b0, 2'd0), mkRes(32'h34000000, 0, 0, 0, 0));
    driveIdle();
    reset = 1'b1;
    sb.delete();
    last_exp = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_reset_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("post_reset_out",   bus.out,            32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
